johnson_counter: RTL and testbench
==================================

# johnson_counter

Bidirectional 8-bit Johnson (twisted-ring) counter with programmable prescaler, synchronous clear and phase load, packaged in the standard Tiny Tapeout user-project pin wrapper. It drives the 16-state Johnson pattern on the dedicated outputs and a decoded phase index, step strobe and sanity flag on the bidirectional pins. It serves as a simple factory/bring-up test design.

## Interface
One clock; reset is synchronous and active-low (`clk`, `rst_n`).
- No parameters. Width is fixed at 8 bits, giving 16 phases.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: synchronous active-low reset.
- `ena` in 1: design selected. When low, state and prescaler hold; clear and load still apply.
- `ui_in` in 8:
  - [0] run.
  - [1] dir: 0 = forward, 1 = reverse.
  - [2] load.
  - [3] clear.
  - [7:4] prescale exponent p.
- `uio_in` in 8: [3:0] load phase; [7:4] ignored.
- `uo_out` out 8: Johnson state register.
- `uio_out` out 8:
  - [3:0] phase index.
  - [4] step strobe.
  - [5] illegal-state flag.
  - [7:6] = 0.
- `uio_oe` out 8: constant 8'b0011_1111.

## Operation
- Forward step: state <= {state[6:0], ~state[7]}. Sequence is 00,01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80, then back to 00.
- Reverse step: state <= {~state[0], state[7:1]}. This is the exact reverse sequence: 00→80→C0→…→01→00.
- Phase index is the position in the forward sequence: 00=0, 0F=4, FF=8, FE=9, 80=15. Forward increments the index mod 16; reverse decrements it mod 16.
- Phase-to-pattern mapping:
  - k ≤ 8: (1<<k)−1.
  - k > 8: 8'hFF << (k−8), truncated to 8 bits.
- Prescaler: 15-bit counter pc.
  - When run & ena: if pc ≥ 2^p − 1, a tick occurs and pc <= 0; else pc <= pc+1.
  - p = 0 ticks every cycle.
  - Using ≥ means a reduced p mid-count ticks immediately.
  - When run = 0 or ena = 0, pc holds.
- A tick advances the state one step in the current dir direction.
- Priority, highest first:
  1. reset: state=00, pc=0, strobe=0.
  2. clear: state=00, pc=0.
  3. load: state=pattern(uio_in[3:0]), pc=0.
  4. tick step.
- Clear and load produce no strobe.
- Illegal flag is combinational from state and is 1 iff the state is not one of the 16 legal patterns. It is unreachable in normal operation and is kept as a structural check.
- Phase index is combinational from state. Illegal states decode to 0.

## Timing
- Reset values: uo_out=00, uio_out=00 (phase 0, strobe 0, flag 0), uio_oe=3F, pc=0.
- A tick sampled at edge N makes the new state visible after edge N. uio_out[4] is registered and is high for exactly the cycle in which the new state first appears.
- With p=0 and run=1, the state changes on every edge and the strobe stays high continuously.
- With exponent p, the interval between steps is 2^p cycles. The first step comes 2^p cycles after run rises from pc=0.
- Clear/load take effect at the next edge, one-cycle latency.
- dir change applies from the next tick; no extra latency.
- Reset asserted mid-count overrides everything at that edge.

## Structure
- Shared package holds:
  - WIDTH=8 and NPHASE=16.
  - Function phase_to_pattern(k).
  - Function pattern_to_phase(s), returning index and legal bit.
- One natural sub-module: `johnson_prescaler` (pc counter plus tick generation). Ring, decode and strobe live in the top level.

## Test plan
- Reset: hold rst_n=0 for 2 cycles → uo_out=00, uio_out=00, uio_oe=3F.
- Forward, ui_in=0x01 (p=0, run, dir=0): 16 cycles step through 01,03,…,FF,FE,…,80,00. uio_out[3:0] goes 1..15,0. Strobe is high and flag is 0 throughout.
- Reverse, ui_in=0x03: from 00 the next states are 80,C0,E0; phase 15,14,13.
- Prescale, ui_in=0x21 (p=2): state changes exactly every 4 cycles. Strobe pulses for 1 cycle per step. Lowering to p=0 mid-count steps on the next edge.
- Load/clear:
  - uio_in=0x9, ui_in[2]=1 → uo_out=FE, phase 9.
  - Load and clear together → 00.
  - run=1 with ena=0 → state holds.
- Reset mid-run at state 3F → 00 next edge; counting resumes from 01 after release.

Source files
------------

// File: rtl/johnson_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : johnson_counter_pkg
// Brief   : Shared widths, types and phase/pattern conversion for the counter.
// Revision: 1.0 - initial release
// ============================================================================
package johnson_counter_pkg;

    localparam int WIDTH  = 8;
    localparam int NPHASE = 16;
    localparam int PC_W   = 15;

    typedef logic [WIDTH-1:0] state_t;
    typedef logic [3:0]       phase_t;

    typedef struct packed {
        logic   legal;
        phase_t idx;
    } decode_t;

    // Phases 0..8 fill ones from the LSB; 9..15 drain them from the LSB.
    function automatic state_t phase_to_pattern(input phase_t k);
        state_t ones;
        ones = '1;
        if (k <= 4'd8) begin
            return state_t'((9'd1 << k) - 9'd1);
        end
        return ones << (k - 4'd8);
    endfunction

    function automatic decode_t pattern_to_phase(input state_t s);
        decode_t d;
        d.legal = 1'b0;
        d.idx   = '0;
        for (int i = 0; i < NPHASE; i++) begin
            if (s == phase_to_pattern(phase_t'(i))) begin
                d.legal = 1'b1;
                d.idx   = phase_t'(i);
            end
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/johnson_prescaler.sv
`default_nettype none
// ============================================================================
// Module  : johnson_prescaler
// Brief   : 15-bit prescale counter producing a step tick every 2^p cycles.
// Revision: 1.0 - initial release
// ============================================================================
module johnson_prescaler
    import johnson_counter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_run,
    input  logic       i_ena,
    input  logic       i_restart,
    input  logic [3:0] i_exp,
    output logic       o_tick
);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_limit;
    logic            w_active;
    logic            w_hit;

    assign w_limit  = PC_W'((16'd1 << i_exp) - 16'd1);
    assign w_active = i_run & i_ena;
    // >= so that lowering the exponent mid-count fires on the next edge
    assign w_hit    = (r_pc >= w_limit);
    assign o_tick   = w_active & w_hit & ~i_restart;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= '0;
        end else if (i_restart) begin
            r_pc <= '0;
        end else if (w_active) begin
            r_pc <= w_hit ? '0 : r_pc + PC_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/johnson_counter.sv
`default_nettype none
// ============================================================================
// Module  : johnson_counter
// Brief   : Bidirectional 8-bit Johnson counter with prescaler, clear and load.
// Revision: 1.0 - initial release
// ============================================================================
module johnson_counter
    import johnson_counter_pkg::*;
(
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    localparam logic [7:0] C_UIO_OE = 8'b0011_1111;

    logic       w_run;
    logic       w_dir;
    logic       w_load;
    logic       w_clear;
    logic [3:0] w_exp;
    logic       w_tick;
    logic       w_unused;
    state_t     r_state;
    state_t     w_fwd;
    state_t     w_rev;
    logic       r_strobe;
    decode_t    w_dec;

    assign w_run    = ui_in[0];
    assign w_dir    = ui_in[1];
    assign w_load   = ui_in[2];
    assign w_clear  = ui_in[3];
    assign w_exp    = ui_in[7:4];
    assign w_unused = &{1'b0, uio_in[7:4]};

    johnson_prescaler u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_run     (w_run),
        .i_ena     (ena),
        .i_restart (w_clear | w_load),
        .i_exp     (w_exp),
        .o_tick    (w_tick)
    );

    assign w_fwd = {r_state[WIDTH-2:0], ~r_state[WIDTH-1]};
    assign w_rev = {~r_state[0], r_state[WIDTH-1:1]};

    // Strobe is registered alongside the state so it marks the new value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= w_tick;
            if (w_clear) begin
                r_state <= '0;
            end else if (w_load) begin
                r_state <= phase_to_pattern(uio_in[3:0]);
            end else if (w_tick) begin
                r_state <= w_dir ? w_rev : w_fwd;
            end
        end
    end

    assign w_dec   = pattern_to_phase(r_state);
    assign uo_out  = r_state;
    assign uio_out = {2'b00, ~w_dec.legal, r_strobe, w_dec.idx};
    assign uio_oe  = C_UIO_OE;

endmodule
`default_nettype wire

// File: tb/tb_johnson_counter.sv
`default_nettype none
// ============================================================================
// Module  : tb_johnson_counter
// Brief   : Phase-level reference model plus directed and random stimulus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_johnson_counter;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    int m_phase  = 0;
    int m_pc     = 0;
    int m_strobe = 0;

    johnson_counter dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_pat(input int k);
        if (k <= 8) return 8'((1 << k) - 1);
        return 8'((255 << (k - 8)) & 255);
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: tracks the phase index, the prescale count and the strobe.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0; m_pc = 0; m_strobe = 0;
        end else if (ui_in[3]) begin
            m_phase = 0; m_pc = 0; m_strobe = 0;
        end else if (ui_in[2]) begin
            m_phase = int'(uio_in[3:0]); m_pc = 0; m_strobe = 0;
        end else begin
            m_strobe = 0;
            if (ui_in[0] && ena) begin
                if (m_pc >= (1 << ui_in[7:4]) - 1) begin
                    m_pc = 0;
                    m_strobe = 1;
                    m_phase = ui_in[1] ? (m_phase + 15) % 16 : (m_phase + 1) % 16;
                end else begin
                    m_pc = m_pc + 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            check("model_state", uo_out, exp_pat(m_phase));
            check("model_uio_out", uio_out, {2'b00, 1'b0, m_strobe[0], 4'(m_phase)});
            check("model_uio_oe", uio_oe, 8'h3F);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [7:0] fwd_seq [16];
        fwd_seq = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                    8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
        rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
        step(1);
        chk_en = 1;
        step(1);
        check("reset_uo_out", uo_out, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'h3F);

        rst_n = 1'b1; ui_in = 8'h01;
        for (int i = 0; i < 16; i++) begin
            step(1);
            check("fwd_state", uo_out, fwd_seq[i]);
            check("fwd_phase", {4'h0, uio_out[3:0]}, 8'((i + 1) % 16));
            check("fwd_strobe_flag", {6'h0, uio_out[5:4]}, 8'h01);
        end

        ui_in = 8'h03;
        step(1); check("rev_state0", uo_out, 8'h80); check("rev_phase0", {4'h0, uio_out[3:0]}, 8'd15);
        step(1); check("rev_state1", uo_out, 8'hC0); check("rev_phase1", {4'h0, uio_out[3:0]}, 8'd14);
        step(1); check("rev_state2", uo_out, 8'hE0); check("rev_phase2", {4'h0, uio_out[3:0]}, 8'd13);

        ui_in = 8'h08;
        step(1); check("clear_state", uo_out, 8'h00);
        ui_in = 8'h21;
        step(3); check("pre_hold", uo_out, 8'h00);
        step(1); check("pre_step", uo_out, 8'h01); check("pre_strobe_hi", {7'h0, uio_out[4]}, 8'h01);
        step(1); check("pre_strobe_lo", {7'h0, uio_out[4]}, 8'h00);
        step(1);
        ui_in = 8'h01;
        step(1); check("pre_reduce", uo_out, 8'h03);

        uio_in = 8'h09; ui_in = 8'h04;
        step(1); check("load9_state", uo_out, 8'hFE); check("load9_phase", {4'h0, uio_out[3:0]}, 8'd9);
        check("load_no_strobe", {7'h0, uio_out[4]}, 8'h00);
        ui_in = 8'h0C;
        step(1); check("load_clear", uo_out, 8'h00);

        uio_in = 8'h05; ui_in = 8'h04;
        step(1);
        ena = 1'b0; ui_in = 8'h01;
        step(3); check("ena_hold", uo_out, 8'h1F);
        ena = 1'b1;

        ui_in = 8'h08; step(1);
        ui_in = 8'h01; step(6); check("mid_run", uo_out, 8'h3F);
        rst_n = 1'b0; step(1); check("mid_reset", uo_out, 8'h00);
        rst_n = 1'b1; step(1); check("resume", uo_out, 8'h01);

        for (int i = 0; i < 500; i++) begin
            logic [3:0] p;
            p = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(3, 6));
            rst_n  = ($urandom_range(0, 99) != 0);
            ena    = ($urandom_range(0, 9) != 0);
            uio_in = 8'($urandom);
            ui_in  = {p, 1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 19) == 0),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0)};
            step(1);
        end

        step(1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
